// File: rtl/wb_arbiter.sv
// wb_arbiter: multi-source writeback stage.
// Completed results from NUM_SRC producers are queued in per-source FIFOs. Each cycle one
// non-empty FIFO is picked round-robin. Its head is lane-extracted and driven onto a
// registered regfile write port. Retired writes (rd != 0) are counted.
// Ports:
//   clk, rst (async, active-low), flush (sync discard of all queued results)
//   src_valid/src_ready             per-source handshake
//   src_rd/src_data/src_fmt/src_mask  per-source entry fields, packed per source
//   wb_we/wb_rd/wb_data             registered regfile write port
//   wb_count                        count of wb_we pulses since reset (wraps)
module wb_arbiter #(
    parameter int unsigned NUM_SRC = 3,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned DEPTH   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic [NUM_SRC*5-1:0]          src_rd,
    input  logic [NUM_SRC*XLEN-1:0]       src_data,
    input  logic [NUM_SRC*3-1:0]          src_fmt,
    input  logic [NUM_SRC*(XLEN/8)-1:0]   src_mask,
    output logic                          wb_we,
    output logic [4:0]                    wb_rd,
    output logic [XLEN-1:0]               wb_data,
    output logic [31:0]                   wb_count
);
    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned SW = $clog2(NUM_SRC);

    logic [4:0]      rd_mem   [NUM_SRC][DEPTH];
    logic [XLEN-1:0] data_mem [NUM_SRC][DEPTH];
    logic [2:0]      fmt_mem  [NUM_SRC][DEPTH];
    logic [NB-1:0]   mask_mem [NUM_SRC][DEPTH];

    logic [PW-1:0] wr_ptr_q [NUM_SRC];
    logic [PW-1:0] rd_ptr_q [NUM_SRC];
    logic [PW:0]   occ_q    [NUM_SRC];

    logic [NUM_SRC-1:0] push, pop, nonempty;
    logic               grant_valid;
    logic [SW-1:0]      grant_idx;
    logic [SW-1:0]      rr_ptr_q, rr_ptr_d;

    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_data;
    logic [2:0]      head_fmt;
    logic [NB-1:0]   head_mask;

    logic            wb_we_q, wb_we_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [31:0]     wb_count_q, wb_count_d;

    // Lane extraction. Masks that do not select a single byte or an aligned halfword fall
    // through as raw data.
    function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] d,
                                                input logic [2:0]      fmt,
                                                input logic [NB-1:0]   m);
        logic [XLEN-1:0] r;
        logic [7:0]      b;
        logic [15:0]     h;
        r = d;
        case (fmt)
            3'd1, 3'd2: begin
                for (int l = 0; l < int'(NB); l++) begin
                    if (m == (NB'(1) << l)) begin
                        b = d[8*l +: 8];
                        r = {{(XLEN-8){(fmt == 3'd1) && b[7]}}, b};
                    end
                end
            end
            3'd3, 3'd4: begin
                for (int j = 0; j < int'(NB / 2); j++) begin
                    if (m == (NB'(3) << (2 * j))) begin
                        h = d[16*j +: 16];
                        r = {{(XLEN-16){(fmt == 3'd3) && h[15]}}, h};
                    end
                end
            end
            3'd5:    r = {{(XLEN-1){1'b0}}, d[0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Ready looks only at registered occupancy, so a full FIFO refuses even while popped.
    always_comb begin
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            src_ready[i] = rst && (occ_q[i] != (PW+1)'(DEPTH));
            nonempty[i]  = (occ_q[i] != '0);
            push[i]      = src_valid[i] && src_ready[i] && !flush;
            pop[i]       = grant_valid && (grant_idx == SW'(i));
        end
    end

    // First non-empty source at or after the RR pointer, wrapping modulo NUM_SRC.
    always_comb begin
        logic [SW:0] idx;
        grant_valid = 1'b0;
        grant_idx   = rr_ptr_q;
        idx         = '0;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            idx = {1'b0, rr_ptr_q} + (SW+1)'(k);
            if (idx >= (SW+1)'(NUM_SRC)) idx = idx - (SW+1)'(NUM_SRC);
            if (!grant_valid && nonempty[idx[SW-1:0]] && !flush) begin
                grant_valid = 1'b1;
                grant_idx   = idx[SW-1:0];
            end
        end
    end

    always_comb begin
        head_rd   = rd_mem[grant_idx][rd_ptr_q[grant_idx]];
        head_data = data_mem[grant_idx][rd_ptr_q[grant_idx]];
        head_fmt  = fmt_mem[grant_idx][rd_ptr_q[grant_idx]];
        head_mask = mask_mem[grant_idx][rd_ptr_q[grant_idx]];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (push[i]) begin
                rd_mem[i][wr_ptr_q[i]]   <= src_rd[i*5 +: 5];
                data_mem[i][wr_ptr_q[i]] <= src_data[i*XLEN +: XLEN];
                fmt_mem[i][wr_ptr_q[i]]  <= src_fmt[i*3 +: 3];
                mask_mem[i][wr_ptr_q[i]] <= src_mask[i*NB +: NB];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                occ_q[i]    <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                occ_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
                if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
                if (push[i] && !pop[i])      occ_q[i] <= occ_q[i] + 1'b1;
                else if (!push[i] && pop[i]) occ_q[i] <= occ_q[i] - 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        wb_we_d    = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        wb_count_d = wb_count_q;
        if (grant_valid) begin
            rr_ptr_d  = (grant_idx == SW'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
            wb_we_d   = (head_rd != 5'd0);
            wb_rd_d   = head_rd;
            wb_data_d = extract(head_data, head_fmt, head_mask);
            if (wb_we_d) wb_count_d = wb_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q   <= '0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_count_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            wb_we_q    <= wb_we_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            wb_count_q <= wb_count_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst && grant_valid && (head_fmt > 3'd5)) begin
            $error("wb_arbiter: reserved fmt %0d on source %0d", head_fmt, grant_idx);
        end
    end
`endif

    assign wb_we    = wb_we_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign wb_count = wb_count_q;

endmodule
